bootram_ctrl: RTL and testbench
===============================

# bootram_ctrl

Bus-side controller for the 8 KiB boot RAM, which is built from four 2K×8 single-port byte lanes (lane i holds byte i of each 32-bit word). It converts the PicoRV32 native memory slave handshake into lane strobes and accounts for the one-cycle read latency of the lanes. It also provides a byte-stream loader port, so a host path such as a UART bootloader can fill the RAM while the CPU is idle. It sits between the SoC address decoder and the four lane instances.

## Interface
Parameters:
- ADDR_W, 13, byte-address bits decoded (8 KiB)
- LOCK_RESET, 1'b0, reset value of CPU write lock

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_s_valid  in  1  CPU request, held until mem_s_ready
- mem_s_ready  out  1  one-cycle completion pulse
- mem_s_addr  in  32  byte address; only [12:2] used, the upstream decoder qualifies valid
- mem_s_wdata  in  32  write data
- mem_s_wstrb  in  4  byte write enables; 0 means read
- mem_s_rdata  out  32  read data, valid while mem_s_ready
- lock_set  in  1  pulse: sets the CPU write lock
- lock  out  1  CPU writes suppressed while high
- ld_start  in  1  pulse: clear load pointer
- ld_valid  in  1  loader byte available
- ld_ready  out  1  loader byte accepted this cycle
- ld_data  in  8  loader byte
- ld_count  out  ADDR_W  current load pointer (bytes written since ld_start)
- ld_wrap  out  1  sticky: pointer wrapped past 8191
- ram_ce  out  1  lane clock enable, shared
- ram_oce  out  1  constant 1
- ram_reset  out  1  equals reset
- ram_ad  out  11  word address, shared
- ram_wre  out  4  per-lane write enable
- ram_din  out  32  lane i data = bits [8i+7:8i]
- ram_dout  in  32  lane i data = bits [8i+7:8i]

## Operation
- FSM has two states:
  - IDLE, entered on reset.
  - ACK.
- IDLE with mem_s_valid=1 (CPU request):
  - ram_ce=1, ram_ad=mem_s_addr[12:2], ram_din=mem_s_wdata, ram_wre=mem_s_wstrb & {4{~lock}}.
  - Next state is ACK.
- ACK:
  - mem_s_ready=1, mem_s_rdata=ram_dout, ram_ce=0, ram_wre=0.
  - Next state is IDLE.
  - The CPU drops valid on the following cycle (PicoRV32 contract).
- mem_s_rdata is 0 whenever mem_s_ready=0.
- Writes while lock=1 still complete with ready, but no lane is written.
- lock is set by lock_set and cleared only by reset.
- Loader access:
  - Granted only in IDLE with mem_s_valid=0 and ld_start=0. The CPU has priority.
  - ld_ready = ld_valid & grant (combinational).
  - On accept: ram_ce=1, ram_ad=ptr[12:2], ram_wre=one-hot(ptr[1:0]), ram_din={4{ld_data}}, then ptr increments.
  - The loader ignores lock.
- Pointer rules:
  - Wrap: ptr 8191 → 0 and ld_wrap is set.
  - ld_start clears ptr and ld_wrap; it wins over a same-cycle ld_valid, so no byte is accepted that cycle.
- Reset values: state IDLE, mem_s_ready 0, mem_s_rdata 0, ld_ready 0, ptr 0, ld_wrap 0, lock LOCK_RESET, ram_ce 0, ram_wre 0, ram_ad 0.

## Timing
- CPU read and write: valid sampled in cycle N → ready in cycle N+1. The lane captures the address at the end of N and ram_dout is valid in N+1. Back-to-back requests take 2 cycles each.
- Loader: 1 byte per cycle when uncontended, so a full 8 KiB fill takes 8192 cycles.
- A CPU request raised in the same cycle as ld_valid is served first; ld_ready is 0 in that cycle and in the ACK cycle.
- Asynchronous reset in ACK:
  - mem_s_ready drops immediately and the state returns to IDLE.
  - The lane write already committed in cycle N stands.

## Structure
- Package bootram_pkg holds:
  - the state enum {ST_IDLE, ST_ACK};
  - BOOTRAM_BYTES=8192, BOOTRAM_LANES=4, LANE_AW=11.
- Sub-module bootram_loader contains the ptr counter, ld_wrap, ld_start handling and the lane one-hot decode. It takes a grant input and produces ld_ready and the write request.
- The four lane instances live in the parent SoC, not in this block.

## Test plan
- Read after reset: valid, addr 0x0 → ready exactly 1 cycle later, rdata = lane init word 0x00000000; second read at addr 0x0C returns the preloaded word.
- Write/read: write 0xDEADBEEF to 0x100 with wstrb 4'b0101, then read → 0x??AD??EF merged with prior bytes; ram_wre observed = 4'b0101 for one cycle.
- Lock: lock_set pulse, write 0x12345678 to 0x200 → ready still 1 cycle later, readback unchanged; ram_wre stays 0.
- Loader stream: ld_start, then bytes 0x11,0x22,0x33,0x44 → ld_count=4; CPU read of 0x0 = 0x44332211. A CPU request injected mid-stream stalls ld_ready for 2 cycles.
- Wrap and start: 8193 loader bytes → ld_wrap=1, ld_count=1, byte 0 overwritten. ld_start with ld_valid in the same cycle → ld_ready=0, ld_count=0, ld_wrap=0.
- Reset mid-ACK: assert reset during the ready cycle → ready=0 in the same cycle, all outputs at reset values, normal operation after release.

Source files
------------

// File: rtl/bootram_pkg.sv
// ----------------------------------------------------------------------------
// bootram_pkg
// Shared types and constants for the boot RAM controller.
//   - state_e       : bus-side FSM states (IDLE, ACK)
//   - BOOTRAM_BYTES : total RAM size in bytes (8 KiB)
//   - BOOTRAM_LANES : number of byte lanes making up one 32-bit word
//   - LANE_AW       : word address width of each 2K x 8 lane
//   - lane_onehot() : byte offset within a word -> lane write strobe
// ----------------------------------------------------------------------------
package bootram_pkg;

    localparam int BOOTRAM_BYTES = 8192;
    localparam int BOOTRAM_LANES = 4;
    localparam int LANE_AW       = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // Byte offset inside a 32-bit word selects exactly one lane.
    function automatic logic [BOOTRAM_LANES-1:0] lane_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/bootram_loader.sv
// ----------------------------------------------------------------------------
// bootram_loader
// Byte-stream loader for the boot RAM. Keeps a byte pointer that advances
// by one for each accepted byte, flags a wrap past the last byte, and turns
// the pointer into a lane word address plus a one-hot lane strobe.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   grant        : parent allows a loader write this cycle
//   ld_start     : pulse, clears pointer and wrap flag (no byte accepted)
//   ld_valid     : a loader byte is offered
//   ld_data      : the offered byte
//   ld_ready     : byte accepted this cycle (combinational)
//   ld_count     : current byte pointer
//   ld_wrap      : sticky, pointer wrapped from the last byte back to 0
//   wr_req       : a lane write is requested this cycle
//   wr_ad        : lane word address for the write
//   wr_wre       : one-hot lane write strobe
//   wr_din       : byte replicated onto all four lanes
// ----------------------------------------------------------------------------
module bootram_loader
    import bootram_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grant,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_data,
    output logic                     ld_ready,
    output logic [ADDR_W-1:0]        ld_count,
    output logic                     ld_wrap,
    output logic                     wr_req,
    output logic [LANE_AW-1:0]       wr_ad,
    output logic [BOOTRAM_LANES-1:0] wr_wre,
    output logic [31:0]              wr_din
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              wrap_q;
    logic              wrap_d;
    logic              accept;

    // ld_start takes precedence: a byte offered in the same cycle is not
    // taken, so the first byte after a start always lands at address 0.
    assign accept   = ld_valid & grant & ~ld_start;
    assign ld_ready = accept;

    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = wrap_q;
        if (ld_start) begin
            ptr_d  = '0;
            wrap_d = 1'b0;
        end else if (accept) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    // The write targets the byte the pointer names before it advances.
    always_comb begin
        wr_req = accept;
        wr_ad  = LANE_AW'(ptr_q >> 2);
        wr_wre = accept ? lane_onehot(ptr_q[1:0]) : '0;
        wr_din = {BOOTRAM_LANES{ld_data}};
    end

    assign ld_count = ptr_q;
    assign ld_wrap  = wrap_q;

endmodule

// File: rtl/bootram_ctrl.sv
// ----------------------------------------------------------------------------
// bootram_ctrl
// Bus-side controller for the 8 KiB boot RAM made of four 2K x 8 byte lanes.
// Converts the PicoRV32 native slave handshake into lane strobes, covers the
// one-cycle lane read latency with an ACK state, and lets a byte-stream
// loader fill the RAM whenever the CPU is not using it.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   mem_s_*          : PicoRV32 native slave (valid/ready, addr, wdata,
//                      wstrb where 0 means read, rdata)
//   lock_set, lock   : sticky CPU write lock (cleared only by reset)
//   ld_*             : loader byte stream (start, valid/ready, data,
//                      byte pointer, wrap flag)
//   ram_*            : shared controls to the four lane instances
//                      (ce, oce, reset, word address, per-lane write
//                      enables, write data, read data)
// ----------------------------------------------------------------------------
module bootram_ctrl
    import bootram_pkg::*;
#(
    parameter int   ADDR_W     = 13,
    parameter logic LOCK_RESET = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     mem_s_valid,
    output logic                     mem_s_ready,
    input  logic [31:0]              mem_s_addr,
    input  logic [31:0]              mem_s_wdata,
    input  logic [3:0]               mem_s_wstrb,
    output logic [31:0]              mem_s_rdata,

    input  logic                     lock_set,
    output logic                     lock,

    input  logic                     ld_start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [7:0]               ld_data,
    output logic [ADDR_W-1:0]        ld_count,
    output logic                     ld_wrap,

    output logic                     ram_ce,
    output logic                     ram_oce,
    output logic                     ram_reset,
    output logic [LANE_AW-1:0]       ram_ad,
    output logic [BOOTRAM_LANES-1:0] ram_wre,
    output logic [31:0]              ram_din,
    input  logic [31:0]              ram_dout
);

    state_e state_q;
    state_e state_d;
    logic   lock_q;
    logic   lock_d;

    logic   cpu_req;
    logic   ld_grant;

    logic                     ld_wr_req;
    logic [LANE_AW-1:0]       ld_wr_ad;
    logic [BOOTRAM_LANES-1:0] ld_wr_wre;
    logic [31:0]              ld_wr_din;

    // Address bits outside the decoded window are qualified upstream.
    logic unused_addr;
    assign unused_addr = ^{mem_s_addr[31:ADDR_W], mem_s_addr[1:0]};

    // While reset is held the state register sits in IDLE; gating with reset
    // keeps a request or byte presented during reset from reaching the lanes.
    assign cpu_req  = (state_q == ST_IDLE) & mem_s_valid & ~reset;
    assign ld_grant = (state_q == ST_IDLE) & ~mem_s_valid & ~ld_start & ~reset;

    bootram_loader #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk      (clk),
        .reset    (reset),
        .grant    (ld_grant),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_count (ld_count),
        .ld_wrap  (ld_wrap),
        .wr_req   (ld_wr_req),
        .wr_ad    (ld_wr_ad),
        .wr_wre   (ld_wr_wre),
        .wr_din   (ld_wr_din)
    );

    // ------------------------------------------------------------------
    // State and lock registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lock_q  <= LOCK_RESET;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    assign lock_d = lock_q | lock_set;

    // ------------------------------------------------------------------
    // Next state and lane/bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_s_ready = 1'b0;
        mem_s_rdata = '0;
        ram_ce      = 1'b0;
        ram_ad      = '0;
        ram_wre     = '0;
        ram_din     = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    // Lane captures address/data at the end of this cycle;
                    // read data is on ram_dout during ACK.
                    ram_ce  = 1'b1;
                    ram_ad  = LANE_AW'(mem_s_addr[ADDR_W-1:2]);
                    ram_din = mem_s_wdata;
                    ram_wre = mem_s_wstrb & {BOOTRAM_LANES{~lock_q}};
                    state_d = ST_ACK;
                end else if (ld_wr_req) begin
                    ram_ce  = 1'b1;
                    ram_ad  = ld_wr_ad;
                    ram_din = ld_wr_din;
                    ram_wre = ld_wr_wre;
                end
            end
            ST_ACK: begin
                // The CPU drops valid after seeing ready, so no request
                // is taken here; a new one is picked up back in IDLE.
                mem_s_ready = 1'b1;
                mem_s_rdata = ram_dout;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lock      = lock_q;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

endmodule

// File: tb/tb_bootram_ctrl.sv
module tb_bootram_ctrl;
    import bootram_pkg::*;

    localparam int ADDR_W = 13;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     mem_s_valid;
    logic                     mem_s_ready;
    logic [31:0]              mem_s_addr;
    logic [31:0]              mem_s_wdata;
    logic [3:0]               mem_s_wstrb;
    logic [31:0]              mem_s_rdata;
    logic                     lock_set;
    logic                     lock;
    logic                     ld_start;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [7:0]               ld_data;
    logic [ADDR_W-1:0]        ld_count;
    logic                     ld_wrap;
    logic                     ram_ce;
    logic                     ram_oce;
    logic                     ram_reset;
    logic [LANE_AW-1:0]       ram_ad;
    logic [BOOTRAM_LANES-1:0] ram_wre;
    logic [31:0]              ram_din;
    logic [31:0]              ram_dout;

    bootram_ctrl #(
        .ADDR_W     (ADDR_W),
        .LOCK_RESET (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_s_valid (mem_s_valid),
        .mem_s_ready (mem_s_ready),
        .mem_s_addr  (mem_s_addr),
        .mem_s_wdata (mem_s_wdata),
        .mem_s_wstrb (mem_s_wstrb),
        .mem_s_rdata (mem_s_rdata),
        .lock_set    (lock_set),
        .lock        (lock),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_count    (ld_count),
        .ld_wrap     (ld_wrap),
        .ram_ce      (ram_ce),
        .ram_oce     (ram_oce),
        .ram_reset   (ram_reset),
        .ram_ad      (ram_ad),
        .ram_wre     (ram_wre),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Four 2K x 8 lanes with registered read (stand-in for the SoC lanes)
    // ------------------------------------------------------------------
    logic [7:0]  lane_mem [BOOTRAM_LANES][2**LANE_AW];
    logic [31:0] lane_dout;

    always @(posedge clk) begin
        if (ram_ce) begin
            for (int i = 0; i < BOOTRAM_LANES; i++) begin
                lane_dout[8*i +: 8] <= lane_mem[i][ram_ad];
                if (ram_wre[i]) lane_mem[i][ram_ad] <= ram_din[8*i +: 8];
            end
        end
    end
    assign ram_dout = lane_dout;

    // ------------------------------------------------------------------
    // Reference model: flat byte array plus lock / pointer / wrap state
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [BOOTRAM_BYTES];
    logic       ref_lock;
    int         ref_ptr;
    logic       ref_wrap;

    function automatic logic [31:0] init_word(input int w);
        return 32'(w) * 32'h9E37_79B1;
    endfunction

    function automatic logic [31:0] ref_word(input int byte_addr);
        return {ref_mem[byte_addr + 3], ref_mem[byte_addr + 2],
                ref_mem[byte_addr + 1], ref_mem[byte_addr]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: expectations pushed at issue, popped when ready shows
    // ------------------------------------------------------------------
    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_s_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'(mem_s_ready), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_read) check("cpu_rdata", mem_s_rdata, mon_e.data);
                    $display("cpu %s addr=0x%08h rdata=0x%08h", mon_e.is_read ? "rd" : "wr",
                             mon_e.addr, mem_s_rdata);
                end
            end else begin
                check("rdata_zero_when_idle", mem_s_rdata, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (called and returning at posedge + 1)
    // ------------------------------------------------------------------
    task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb);
        exp_t e;
        int   a;
        logic [3:0] exp_wre;
        a = int'(addr[12:2]) * 4;
        mem_s_valid = 1'b1;
        mem_s_addr  = addr;
        mem_s_wdata = wdata;
        mem_s_wstrb = wstrb;
        e.is_read = (wstrb == 4'd0);
        e.addr    = addr;
        e.data    = ref_word(a);
        sb_q.push_back(e);
        exp_wre = ref_lock ? 4'd0 : wstrb;
        if (!ref_lock) begin
            for (int i = 0; i < 4; i++) if (wstrb[i]) ref_mem[a + i] = wdata[8*i +: 8];
        end
        #2;
        check("issue_ce", 32'(ram_ce), 32'd1);
        check("issue_ad", 32'(ram_ad), 32'(addr[12:2]));
        check("issue_wre", 32'(ram_wre), 32'(exp_wre));
        @(posedge clk); #1;
        check("ready_latency", 32'(mem_s_ready), 32'd1);
        check("ack_wre", 32'(ram_wre), 32'd0);
        check("ack_ce", 32'(ram_ce), 32'd0);
        @(posedge clk); #1;
        mem_s_valid = 1'b0;
        mem_s_wstrb = 4'd0;
    endtask

    logic [7:0] ld_fixed[$];

    task automatic ld_stream(input int n, input int exp_stalls, input bit do_start);
        int got    = 0;
        int stalls = 0;
        int cyc    = 0;
        if (do_start) begin
            ld_start = 1'b1;
            ld_valid = 1'b0;
            @(posedge clk); #1;
            ld_start = 1'b0;
            ref_ptr  = 0;
            ref_wrap = 1'b0;
        end
        ld_data  = (ld_fixed.size() != 0) ? ld_fixed.pop_front() : 8'($urandom);
        ld_valid = 1'b1;
        while (got < n && cyc < n + 100) begin
            #3;
            if (ld_ready) begin
                ref_mem[ref_ptr] = ld_data;
                if (ref_ptr == BOOTRAM_BYTES - 1) ref_wrap = 1'b1;
                ref_ptr = (ref_ptr + 1) % BOOTRAM_BYTES;
                got++;
                @(posedge clk); #1;
                ld_data = (ld_fixed.size() != 0) ? ld_fixed.pop_front() : 8'($urandom);
            end else begin
                stalls++;
                @(posedge clk); #1;
            end
            cyc++;
        end
        ld_valid = 1'b0;
        check("ld_accepted", 32'(got), 32'(n));
        check("ld_stalls", 32'(stalls), 32'(exp_stalls));
        check("ld_count", 32'(ld_count), 32'(ref_ptr));
        check("ld_wrap", 32'(ld_wrap), 32'(ref_wrap));
        $display("load bytes=%0d stalls=%0d count=%0d wrap=%0b", got, stalls, ld_count, ld_wrap);
    endtask

    task automatic random_cpu_ops(input int n);
        logic [31:0] a;
        logic [3:0]  s;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            a[12:2] = 11'($urandom_range(0, 31));
            s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            cpu_access(a, $urandom, s);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int w = 0; w < BOOTRAM_BYTES / 4; w++) begin
            for (int i = 0; i < 4; i++) begin
                lane_mem[i][w]     = init_word(w)[8*i +: 8];
                ref_mem[w * 4 + i] = init_word(w)[8*i +: 8];
            end
        end
        lane_dout = 32'd0;
        ref_lock  = 1'b0;
        ref_ptr   = 0;
        ref_wrap  = 1'b0;

        // Reset with requests pending: nothing may reach the lanes.
        reset       = 1'b1;
        mem_s_valid = 1'b1;
        mem_s_addr  = 32'h0000_0040;
        mem_s_wdata = 32'h0;
        mem_s_wstrb = 4'hF;
        lock_set    = 1'b0;
        ld_start    = 1'b0;
        ld_valid    = 1'b1;
        ld_data     = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(mem_s_ready), 32'd0);
        check("rst_rdata", mem_s_rdata, 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_ld_count", 32'(ld_count), 32'd0);
        check("rst_ld_wrap", 32'(ld_wrap), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_ram_ce", 32'(ram_ce), 32'd0);
        check("rst_ram_wre", 32'(ram_wre), 32'd0);
        check("rst_ram_ad", 32'(ram_ad), 32'd0);
        check("rst_ram_oce", 32'(ram_oce), 32'd1);
        check("rst_ram_reset", 32'(ram_reset), 32'd1);
        mem_s_valid = 1'b0;
        mem_s_wstrb = 4'd0;
        ld_valid    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("ram_reset_release", 32'(ram_reset), 32'd0);
        @(posedge clk); #1;

        // Reads after reset, then a partial write merged with old bytes.
        cpu_access(32'h0000_0000, 32'h0, 4'd0);
        cpu_access(32'h0000_000C, 32'h0, 4'd0);
        cpu_access(32'h0000_0100, 32'hDEAD_BEEF, 4'b0101);
        cpu_access(32'h0000_0100, 32'h0, 4'd0);

        random_cpu_ops(80);

        // Loader stream of four known bytes, then CPU readback.
        ld_fixed = '{8'h11, 8'h22, 8'h33, 8'h44};
        ld_stream(4, 0, 1'b1);
        check("ld_count_four", 32'(ld_count), 32'd4);
        cpu_access(32'h0000_0000, 32'h0, 4'd0);

        // CPU request injected mid-stream stalls the loader for two cycles.
        fork
            ld_stream(12, 2, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #1;
                cpu_access(32'h0000_0804, 32'h0, 4'd0);
            end
        join
        cpu_access(32'h0000_0008, 32'h0, 4'd0);

        // Full fill plus one byte: pointer wraps and byte 0 is overwritten.
        ld_stream(BOOTRAM_BYTES + 1, 0, 1'b1);
        check("wrap_count", 32'(ld_count), 32'd1);
        check("wrap_flag", 32'(ld_wrap), 32'd1);
        cpu_access(32'h0000_0000, 32'h0, 4'd0);
        cpu_access(32'h0000_1FFC, 32'h0, 4'd0);

        // ld_start wins over a same-cycle ld_valid.
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        #3;
        check("start_ld_ready", 32'(ld_ready), 32'd0);
        check("start_ram_wre", 32'(ram_wre), 32'd0);
        @(posedge clk); #1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ref_ptr  = 0;
        ref_wrap = 1'b0;
        check("start_ld_count", 32'(ld_count), 32'd0);
        check("start_ld_wrap", 32'(ld_wrap), 32'd0);
        $display("load start-with-valid count=%0d wrap=%0b", ld_count, ld_wrap);

        // Lock: writes complete but leave the lanes untouched.
        lock_set = 1'b1;
        @(posedge clk); #1;
        lock_set = 1'b0;
        ref_lock = 1'b1;
        check("lock_set", 32'(lock), 32'd1);
        cpu_access(32'h0000_0200, 32'h1234_5678, 4'hF);
        cpu_access(32'h0000_0200, 32'h0, 4'd0);
        random_cpu_ops(20);

        // Loader ignores the lock.
        ld_stream(3, 0, 1'b1);
        cpu_access(32'h0000_0000, 32'h0, 4'd0);

        // Asynchronous reset during ACK.
        mem_s_valid = 1'b1;
        mem_s_addr  = 32'h0000_0040;
        mem_s_wstrb = 4'd0;
        @(posedge clk); #1;
        check("pre_reset_ready", 32'(mem_s_ready), 32'd1);
        #1;
        reset    = 1'b1;
        ld_valid = 1'b1;
        #1;
        check("ackrst_ready", 32'(mem_s_ready), 32'd0);
        check("ackrst_rdata", mem_s_rdata, 32'd0);
        check("ackrst_ram_ce", 32'(ram_ce), 32'd0);
        check("ackrst_ram_wre", 32'(ram_wre), 32'd0);
        check("ackrst_ram_ad", 32'(ram_ad), 32'd0);
        check("ackrst_ld_ready", 32'(ld_ready), 32'd0);
        check("ackrst_ld_count", 32'(ld_count), 32'd0);
        check("ackrst_ld_wrap", 32'(ld_wrap), 32'd0);
        check("ackrst_lock", 32'(lock), 32'd0);
        $display("reset during ack ready=%0b lock=%0b count=%0d", mem_s_ready, lock, ld_count);
        mem_s_valid = 1'b0;
        ld_valid    = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        ref_lock = 1'b0;
        ref_ptr  = 0;
        ref_wrap = 1'b0;
        @(posedge clk); #1;

        // Normal operation after release.
        random_cpu_ops(30);
        ld_fixed = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ld_stream(4, 0, 1'b0);
        cpu_access(32'h0000_0000, 32'h0, 4'd0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
